// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional two-entry skid buffer and stall counter
// Ports:
//   clk, reset (async, active-low), flush (sync kill of held entries)
//   in_valid/in_ready/in_data    upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and oldest payload
//   stall_cnt                    saturating count of cycles with out_valid & ~out_ready
module pipe_stage_reg #(
   parameter int WIDTH = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int SKID = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] main_q, skid_q, main_n, skid_n;
   logic acc, cons;
   assign out_valid = state != EMPTY;
   assign out_data = out_valid ? main_q : RESET_VAL;
   // with a skid entry, ready depends only on registered state; without one, ready passes out_ready through
   assign in_ready = (SKID != 0) ? state != TWO : ~out_valid | out_ready;
   assign acc = in_valid & in_ready;
   assign cons = out_valid & out_ready;
   always_comb begin
      state_n = state;
      main_n = main_q;
      skid_n = skid_q;
      if (flush) begin
         state_n = EMPTY;
         main_n = RESET_VAL;
         skid_n = RESET_VAL;
      end else if (state == TWO) begin
         if (cons) begin
            state_n = ONE;
            main_n = skid_q;
         end
      end else if (acc) begin
         if (state == EMPTY || cons) begin
            state_n = ONE;
            main_n = in_data;
         end else begin
            state_n = TWO;
            skid_n = in_data;
         end
      end else if (cons) begin
         state_n = EMPTY;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
         main_q <= RESET_VAL;
         skid_q <= RESET_VAL;
         stall_cnt <= '0;
      end else begin
         state <= state_n;
         main_q <= main_n;
         skid_q <= skid_n;
         if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (skid, saturating-counter and no-skid variants)
module tb_pipe_stage_reg;
   localparam logic [63:0] RV = 64'hDEAD_BEEF_0000_0001;
   localparam logic [15:0] RV2 = 16'h00A5;
   logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic [63:0] in_data = '0;
   logic ns_in_valid = 0, ns_out_ready = 0, ns_flush = 0;
   logic [15:0] ns_in_data = '0;
   logic in_ready, out_valid, sat_in_ready, sat_out_valid, ns_in_ready, ns_out_valid;
   logic [63:0] out_data, sat_out_data;
   logic [15:0] stall_cnt, ns_out_data, ns_stall_cnt;
   logic [3:0] sat_stall_cnt;
   int checks = 0, errors = 0;
   logic [63:0] q[$];
   logic [15:0] q2[$];
   int unsigned cnt = 0, cnt2 = 0;
   always #5 clk = ~clk;
   pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV), .SKID(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt));
   pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV), .SKID(1), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(sat_in_ready),
      .in_data(in_data), .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
      .stall_cnt(sat_stall_cnt));
   pipe_stage_reg #(.WIDTH(16), .RESET_VAL(RV2), .SKID(0), .CNT_W(16)) u_ns (
      .clk(clk), .reset(reset), .flush(ns_flush), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
      .in_data(ns_in_data), .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
      .stall_cnt(ns_stall_cnt));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step();
      bit acc, cons, st, acc2, cons2, st2;
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_data", out_data, q.size() != 0 ? q[0] : RV);
      chk("in_ready", in_ready, q.size() < 2);
      chk("stall_cnt", stall_cnt, cnt);
      chk("sat_cnt", sat_stall_cnt, cnt > 15 ? 15 : cnt);
      chk("ns_out_valid", ns_out_valid, q2.size() != 0);
      chk("ns_out_data", ns_out_data, q2.size() != 0 ? q2[0] : RV2);
      chk("ns_in_ready", ns_in_ready, q2.size() == 0 || ns_out_ready);
      chk("ns_stall_cnt", ns_stall_cnt, cnt2);
      acc = in_valid && q.size() < 2;
      cons = q.size() != 0 && out_ready;
      st = q.size() != 0 && !out_ready;
      acc2 = ns_in_valid && (q2.size() == 0 || ns_out_ready);
      cons2 = q2.size() != 0 && ns_out_ready;
      st2 = q2.size() != 0 && !ns_out_ready;
      @(posedge clk);
      #1;
      if (st && cnt < 65535) cnt++;
      if (st2 && cnt2 < 65535) cnt2++;
      if (flush) q.delete();
      else begin
         if (cons) void'(q.pop_front());
         if (acc) q.push_back(in_data);
      end
      if (cons2) void'(q2.pop_front());
      if (acc2) q2.push_back(ns_in_data);
   endtask
   initial begin
      #2 reset = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, RV);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_ns_data", ns_out_data, RV2);
      #5 reset = 1;
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1;
         in_data = i;
         step();
      end
      in_valid = 0;
      repeat (2) step();
      out_ready = 0;
      in_valid = 1;
      in_data = 64'hA;
      step();
      in_data = 64'hB;
      step();
      in_valid = 0;
      repeat (2) step();
      out_ready = 1;
      repeat (3) step();
      out_ready = 0;
      in_valid = 1;
      in_data = 5;
      step();
      in_data = 6;
      step();
      in_data = 7;
      flush = 1;
      step();
      flush = 0;
      in_valid = 0;
      step();
      out_ready = 1;
      repeat (2) step();
      out_ready = 0;
      in_valid = 1;
      in_data = 64'h1234;
      step();
      in_valid = 0;
      repeat (2) step();
      #2 reset = 0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, RV);
      chk("arst_stall", stall_cnt, 0);
      chk("arst_in_ready", in_ready, 1);
      q.delete();
      q2.delete();
      cnt = 0;
      cnt2 = 0;
      #2 reset = 1;
      in_valid = 1;
      in_data = 64'h55;
      step();
      in_valid = 0;
      repeat (20) step();
      out_ready = 1;
      repeat (2) step();
      ns_in_valid = 1;
      ns_in_data = 16'h11;
      ns_out_ready = 0;
      step();
      ns_in_data = 16'h22;
      #1;
      chk("ns_hold_ready", ns_in_ready, 0);
      ns_out_ready = 1;
      #1;
      chk("ns_pass_ready", ns_in_ready, 1);
      ns_out_ready = 0;
      step();
      ns_out_ready = 1;
      step();
      ns_in_valid = 0;
      repeat (2) step();
      for (int i = 0; i < 300; i++) begin
         in_valid = $urandom_range(0, 1);
         in_data = {$urandom, $urandom};
         out_ready = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 15) == 0;
         ns_in_valid = $urandom_range(0, 1);
         ns_in_data = 16'($urandom);
         ns_out_ready = $urandom_range(0, 1);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
